// File: rtl/aes_key_schedule_if.sv
// Key-load and round-key read interface of the AES key schedule.
// The master is the key-loading front end plus the core; the slave is the key schedule.
interface aes_key_schedule_if;
  logic         key_valid;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         key_ready;
  logic [3:0]   Nr;
  logic [3:0]   Addr;
  logic [128:0] Key;

  modport master (
    output key_valid, key_in, key_len, Addr,
    input  key_ready, Nr, Key
  );

  modport slave (
    input  key_valid, key_in, key_len, Addr,
    output key_ready, Nr, Key
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES round-key provider: expands a 128/192/256-bit key one word per cycle into a
// 60-word register file and serves round key Addr combinationally on Key.
module aes_key_schedule (
  input logic               clk,
  input logic               rst,
  aes_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExpand, StReady} state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q [60];
  logic [5:0]  i_q, i_d;
  logic [2:0]  imod_q, imod_d;   // i mod Nk, kept as a wrapping counter
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  nk_q, nk_d;
  logic [3:0]  nr_q, nr_d;

  logic        accept;
  logic        exp_we;
  logic [31:0] w_new;
  logic [31:0] prev, back, rot, sub_in, sub_out, t;
  logic [5:0]  last_idx;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'd254;
    for (int k = 7; k >= 0; k--) begin
      r = gf_mul(r, r);
      if (e[k]) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
           ^ 8'h63;
  endfunction

  assign accept = bus.key_valid && (state_q != StExpand);
  assign exp_we = (state_q == StExpand);

  // Word-generation datapath for w[i]
  always_comb begin
    prev     = w_q[i_q - 6'd1];
    back     = w_q[i_q - {2'b00, nk_q}];
    rot      = {prev[7:0], prev[31:8]};   // byte 0 moves to byte 3
    sub_in   = (imod_q == 3'd0) ? rot : prev;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]),
                sbox(sub_in[7:0])};
    if (imod_q == 3'd0) begin
      t = sub_out ^ {24'h0, rcon_q};
    end else if (nk_q == 4'd8 && imod_q == 3'd4) begin
      t = sub_out;
    end else begin
      t = prev;
    end
    w_new    = back ^ t;
    last_idx = {nr_q, 2'b00} + 6'd3;
  end

  // FSM next state plus index, rcon and key-size bookkeeping
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    imod_d  = imod_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    unique case (state_q)
      StIdle, StReady: begin
        if (accept) begin
          state_d = StExpand;
          unique case (bus.key_len)
            2'd1:    begin nk_d = 4'd6; nr_d = 4'd12; end
            2'd2:    begin nk_d = 4'd8; nr_d = 4'd14; end
            default: begin nk_d = 4'd4; nr_d = 4'd10; end
          endcase
          i_d    = {2'b00, nk_d};
          imod_d = 3'd0;
          rcon_d = 8'h01;
        end
      end
      StExpand: begin
        i_d    = i_q + 6'd1;
        imod_d = ({1'b0, imod_q} == nk_q - 4'd1) ? 3'd0 : imod_q + 3'd1;
        if (imod_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_idx) state_d = StReady;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      imod_q  <= '0;
      rcon_q  <= 8'h01;
      nk_q    <= '0;
      nr_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      imod_q  <= imod_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
    end
  end

  // Register file: bulk load of the cipher key on accept, one generated word per EXPAND cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 60; j++) w_q[j] <= '0;
    end else if (accept) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(nk_d)) w_q[j] <= bus.key_in[32*j +: 32];
      end
    end else if (exp_we) begin
      w_q[i_q] <= w_new;
    end
  end

  // Zero-latency read of round key Addr; zeroed unless READY and in range
  always_comb begin
    logic [5:0] base;
    logic       valid;
    valid         = (state_q == StReady) && (bus.Addr <= nr_q);
    base          = valid ? {bus.Addr, 2'b00} : 6'd0;
    bus.Key       = '0;
    if (valid) begin
      bus.Key = {1'b1, w_q[base + 6'd3], w_q[base + 6'd2], w_q[base + 6'd1], w_q[base]};
    end
    bus.key_ready = (state_q != StExpand);
    bus.Nr        = nr_q;
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 appendix A and C.1 key vectors.
module tb_aes_key_schedule;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  aes_key_schedule_if u_if ();

  aes_key_schedule u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS-order round keys of the A.1 key
  logic [127:0] rk_a1 [11];

  localparam logic [127:0] KeyA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KeyA2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KeyA3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RkC1R3 = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;

  function automatic logic [255:0] brev256(input logic [255:0] v);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = v[8*(31-k) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] brev128(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = v[8*(15-k) +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a key for one accept edge, then count edges until key_ready returns
  task automatic load_key(input string tag, input logic [255:0] kin, input logic [1:0] len,
                          input int nr_exp, input int cyc_exp);
    int n;
    @(negedge clk);
    u_if.key_valid = 1'b1;
    u_if.key_in    = kin;
    u_if.key_len   = len;
    @(posedge clk);
    #1;
    u_if.key_valid = 1'b0;
    check({tag, "_busy"}, 129'(u_if.key_ready), 129'(0));
    check({tag, "_kvalid_low"}, 129'(u_if.Key[128]), 129'(0));
    check({tag, "_nr_at_e0"}, 129'(u_if.Nr), 129'(nr_exp));
    n = 0;
    while (!u_if.key_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_cycles"}, 129'(n), 129'(cyc_exp));
  endtask

  task automatic read_key(input logic [3:0] a);
    @(negedge clk);
    u_if.Addr = a;
    #2;
  endtask

  initial begin
    rk_a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    u_if.key_valid = 1'b0;
    u_if.key_in    = '0;
    u_if.key_len   = 2'd0;
    u_if.Addr      = 4'd0;
    #1;
    check("rst_key_ready", 129'(u_if.key_ready), 129'(1));
    check("rst_nr", 129'(u_if.Nr), 129'(0));
    check("rst_key", u_if.Key, 129'(0));
    @(negedge clk);
    rst = 1'b0;

    // 128-bit key, full zero-latency sweep including out-of-range addresses
    load_key("a1", brev256({KeyA1, 128'h0}), 2'd0, 10, 40);
    read_key(4'd0);
    check("a1_addr0", u_if.Key, {1'b1, brev128(KeyA1)});
    read_key(4'd10);
    check("a1_addr10", u_if.Key, {1'b1, 128'ha60c63b6c80c3fe18925eec9a8f914d0});
    for (int a = 0; a < 16; a++) begin
      read_key(4'(a));
      check($sformatf("sweep_addr%0d", a), u_if.Key,
            (a <= 10) ? {1'b1, brev128(rk_a1[a])} : 129'(0));
    end

    // 192-bit key
    load_key("a2", brev256({KeyA2, 64'h0}), 2'd1, 12, 46);
    read_key(4'd0);
    check("a2_addr0", u_if.Key, {1'b1, brev128(KeyA2[191:64])});
    read_key(4'd12);
    check("a2_w51", 129'(u_if.Key[127:96]), 129'(32'h02220001));
    check("a2_addr12_valid", 129'(u_if.Key[128]), 129'(1));
    read_key(4'd13);
    check("a2_addr13", u_if.Key, 129'(0));

    // 256-bit key; w[59] depends on the i mod 8 == 4 SubWord step
    load_key("a3", brev256(KeyA3), 2'd2, 14, 52);
    read_key(4'd14);
    check("a3_w59", 129'(u_if.Key[127:96]), 129'(32'h1e636c70));
    check("a3_addr14_valid", 129'(u_if.Key[128]), 129'(1));
    read_key(4'd1);
    check("a3_addr1", u_if.Key, {1'b1, brev128(KeyA3[127:0])});
    read_key(4'd15);
    check("a3_addr15", u_if.Key, 129'(0));

    // Rekey from READY with Addr held at 3
    read_key(4'd3);
    check("rekey_pre_valid", 129'(u_if.Key[128]), 129'(1));
    load_key("c1", brev256({KeyC1, 128'h0}), 2'd0, 10, 40);
    check("c1_addr3", u_if.Key, {1'b1, brev128(RkC1R3)});

    // Reset in the middle of an expansion, then reload
    u_if.Addr = 4'd0;
    @(negedge clk);
    u_if.key_valid = 1'b1;
    u_if.key_in    = brev256({KeyA1, 128'h0});
    u_if.key_len   = 2'd0;
    @(posedge clk);
    #1;
    u_if.key_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_key_ready", 129'(u_if.key_ready), 129'(1));
    check("midrst_nr", 129'(u_if.Nr), 129'(0));
    check("midrst_key", u_if.Key, 129'(0));
    @(negedge clk);
    rst = 1'b0;
    load_key("reload", brev256({KeyA1, 128'h0}), 2'd0, 10, 40);
    read_key(4'd10);
    check("reload_addr10", u_if.Key, {1'b1, brev128(rk_a1[10])});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
